// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single-command memory bus.
// One transaction at a time: grant, issue, optional read wait, one-cycle ack.
module mem_bus_arbiter #(
   parameter int AW = 9,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req0_valid,
   input  logic          req0_write,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ack,
   input  logic          req1_valid,
   input  logic          req1_write,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ack,
   output logic [DW-1:0] rd_data,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] write_data,
   input  logic [DW-1:0] read_data,
   output logic          busy,
   output logic          grant_id
);

   // state  | meaning
   // IDLE   | bus free, arbitrate any valid requester at the next edge
   // ISSUE  | drive the latched command on the bus for one cycle
   // RDWAIT | bus returns read_data; captured at the exit edge
   // ACK    | one-cycle ack to the granted requester
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_ACK} state_t;

   state_t        state_q, state_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rd_q, rd_d;
   logic          grant_q, grant_d;
   logic          last_q, last_d;
   logic          sel;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      grant_d = grant_q;
      last_d  = last_q;
      // With both valid, the one that did not win last time gets the bus
      sel     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
      case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               grant_d = sel;
               last_d  = sel;
               wr_d    = sel ? req1_write : req0_write;
               addr_d  = sel ? req1_addr  : req0_addr;
               wdata_d = sel ? req1_wdata : req0_wdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE:  state_d = wr_q ? S_ACK : S_RDWAIT;
         S_RDWAIT: begin
            rd_d    = read_data;
            state_d = S_ACK;
         end
         S_ACK:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign mem_cmd    = (state_q == S_ISSUE) ? {1'b0, wr_q} : 2'b10;
   assign mem_addr   = addr_q;
   assign write_data = wdata_q;
   assign rd_data    = rd_q;
   assign busy       = (state_q != S_IDLE);
   assign grant_id   = grant_q;
   assign req0_ack   = (state_q == S_ACK) && !grant_q;
   assign req1_ack   = (state_q == S_ACK) && grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected bus commands and acks are
// queued when requests are driven and checked as the bus/acks appear.
module tb_mem_bus_arbiter;

   localparam int AW = 9;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0_valid = 1'b0, req0_write = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req0_ack;
   logic          req1_valid = 1'b0, req1_write = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          req1_ack;
   logic [DW-1:0] rd_data;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data = '0;
   logic          busy;
   logic          grant_id;

   mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ack(req0_ack),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ack(req1_ack),
      .rd_data(rd_data), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .write_data(write_data), .read_data(read_data),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          id;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            issue_at;   // -1: cycle not predicted
   } txn_t;

   txn_t          exp_q[$];
   txn_t          cur;
   bit            cur_valid = 0;
   int            issue_cyc = 0;
   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] last_rd = '0;
   bit            rd_arm = 0;
   logic [DW-1:0] rd_val = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // read_data carries the expected word only during the RDWAIT cycle
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rd_arm) begin
         read_data = rd_val;
         rd_arm    = 0;
      end else begin
         read_data = DW'($urandom);
      end
   end

   always @(negedge clk) begin
      if (mem_cmd != 2'b10) begin
         if (exp_q.size() == 0) begin
            check_eq("bus_unexpected", 32'(mem_cmd), 32'h2);
         end else begin
            cur       = exp_q.pop_front();
            cur_valid = 1;
            issue_cyc = cyc;
            check_eq("bus_cmd", 32'(mem_cmd), cur.wr ? 32'h1 : 32'h0);
            check_eq("bus_addr", 32'(mem_addr), 32'(cur.addr));
            check_eq("bus_grant", 32'(grant_id), 32'(cur.id));
            check_eq("bus_busy", 32'(busy), 32'h1);
            if (cur.wr) check_eq("bus_wdata", 32'(write_data), 32'(cur.wdata));
            if (cur.issue_at >= 0) check_eq("issue_latency", cyc, cur.issue_at);
            if (!cur.wr) begin
               rd_val = cur.rdata;
               rd_arm = 1;
            end
         end
      end
      if (req0_ack || req1_ack) begin
         check_eq("ack_overlap", 32'(req0_ack & req1_ack), 32'h0);
         if (!cur_valid) begin
            check_eq("ack_unexpected", 32'({req1_ack, req0_ack}), 32'h0);
         end else begin
            check_eq("ack_id", 32'(req1_ack), 32'(cur.id));
            check_eq("ack_latency", cyc - issue_cyc, cur.wr ? 1 : 2);
            if (!cur.wr) last_rd = cur.rdata;
            check_eq("ack_rd_data", 32'(rd_data), 32'(last_rd));
            cur_valid = 0;
         end
      end
   end

   task automatic drive_req(input bit id, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      if (id) begin
         req1_write = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
      end else begin
         req0_write = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
      end
   endtask

   task automatic single(input bit id, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] rd, input bit change);
      bit got;
      @(negedge clk);
      exp_q.push_back('{id: id, wr: wr, addr: a, wdata: d, rdata: rd, issue_at: cyc + 1});
      drive_req(id, wr, a, d);
      if (change) begin
         @(posedge clk);
         #1;
         if (id) begin req1_addr = ~a; req1_wdata = ~d; end
         else    begin req0_addr = ~a; req0_wdata = ~d; end
      end
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (id ? req1_ack : req0_ack) got = 1;
      end
      check_eq("ack_seen", 32'(got), 32'h1);
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_acks(input bit id, input int n);
      int cnt = 0;
      for (int i = 0; i < 100 && cnt < n; i++) begin
         @(negedge clk);
         if (id ? req1_ack : req0_ack) cnt++;
      end
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      check_eq("contend_acks", cnt, n);
   endtask

   // Both requesters held valid: req0 writes, req1 reads; grants must alternate from 0
   task automatic contend(input int pairs, input logic [DW-1:0] rdv);
      @(negedge clk);
      for (int k = 0; k < pairs; k++) begin
         exp_q.push_back('{id: 1'b0, wr: 1'b1, addr: 9'h0AA, wdata: 16'h1111, rdata: '0,
                           issue_at: (k == 0) ? cyc + 1 : -1});
         exp_q.push_back('{id: 1'b1, wr: 1'b0, addr: 9'h055, wdata: 16'h2222, rdata: rdv,
                           issue_at: -1});
      end
      drive_req(1'b0, 1'b1, 9'h0AA, 16'h1111);
      drive_req(1'b1, 1'b0, 9'h055, 16'h2222);
      fork
         wait_acks(1'b0, pairs);
         wait_acks(1'b1, pairs);
      join
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_cmd", 32'(mem_cmd), 32'h2);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_grant", 32'(grant_id), 32'h0);
      check_eq("rst_rd_data", 32'(rd_data), 32'h0);
      check_eq("rst_addr", 32'(mem_addr), 32'h0);
      check_eq("rst_wdata", 32'(write_data), 32'h0);
      check_eq("rst_acks", 32'({req1_ack, req0_ack}), 32'h0);
      reset_n = 1'b1;

      contend(2, 16'hC0DE);
      single(1'b0, 1'b1, 9'h100, 16'h00A5, 16'h0000, 1'b0);
      single(1'b1, 1'b0, 9'h010, 16'h0000, 16'h1234, 1'b0);
      check_eq("rd_data_1234", 32'(rd_data), 32'h1234);
      single(1'b0, 1'b1, 9'h1F0, 16'hBEEF, 16'h0000, 1'b1);
      check_eq("rd_hold_after_wr", 32'(rd_data), 32'h1234);
      single(1'b0, 1'b0, 9'h1FF, 16'h0000, 16'hFFFF, 1'b1);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle_cmd", 32'(mem_cmd), 32'h2);
         check_eq("idle_busy", 32'(busy), 32'h0);
         check_eq("idle_acks", 32'({req1_ack, req0_ack}), 32'h0);
      end

      // Reset while a read sits in RDWAIT
      @(negedge clk);
      exp_q.push_back('{id: 1'b1, wr: 1'b0, addr: 9'h033, wdata: '0, rdata: 16'h7777,
                        issue_at: cyc + 1});
      drive_req(1'b1, 1'b0, 9'h033, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      reset_n    = 1'b0;
      req1_valid = 1'b0;
      cur_valid  = 0;
      @(negedge clk);
      last_rd = '0;
      check_eq("abort_busy", 32'(busy), 32'h0);
      check_eq("abort_cmd", 32'(mem_cmd), 32'h2);
      check_eq("abort_rd_data", 32'(rd_data), 32'h0);
      check_eq("abort_grant", 32'(grant_id), 32'h0);
      check_eq("abort_addr", 32'(mem_addr), 32'h0);
      check_eq("abort_acks", 32'({req1_ack, req0_ack}), 32'h0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      contend(1, 16'h0F0F);

      repeat (5) @(negedge clk);
      check_eq("sb_empty", exp_q.size(), 0);
      check_eq("sb_no_pending", 32'(cur_valid), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 9, memory address width; DW, 16, data width.
REQ-002 Ports SHALL be, in this order:
- clk  input  1  sole clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- req0_valid  input  1  requester 0 has a pending transaction
- req0_write  input  1  requester 0 op: 1 write, 0 read
- req0_addr  input  AW  requester 0 address
- req0_wdata  input  DW  requester 0 write data
- req0_ack  output  1  one-cycle completion pulse to requester 0
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ack  same as requester 0, for requester 1
- rd_data  output  DW  registered read result, valid while an ack for a read is high
- mem_cmd  output  2  shared bus command: 2'b00 read, 2'b01 write, 2'b10 none
- mem_addr  output  AW  shared bus address
- write_data  output  DW  shared bus write data
- read_data  input  DW  bus read data, valid the cycle after mem_cmd=read
- busy  output  1  high in any state other than IDLE
- grant_id  output  1  requester currently owning the bus; holds the last owner in IDLE

Function
REQ-003 The block SHALL have one FSM with states IDLE, ISSUE, RDWAIT and ACK.
REQ-004 In IDLE with no reqN_valid high, the FSM SHALL remain in IDLE with mem_cmd=2'b10.
REQ-005 In IDLE with one or more reqN_valid high, arbitration SHALL occur at the clock edge:
- Only one requester valid: grant it.
- Both valid: grant the requester not equal to last_grant (round-robin).
REQ-006 At the arbitration edge, the block SHALL:
- Latch the granted requester's write, addr and wdata into internal registers.
- Set grant_id and last_grant to the granted index.
- Move to ISSUE.
REQ-007 In ISSUE, the block SHALL drive:
- mem_cmd = 2'b01 (write) or 2'b00 (read), for exactly one cycle.
- mem_addr and write_data from the latched registers.
REQ-008 From ISSUE, a write SHALL go to ACK and a read SHALL go to RDWAIT.
REQ-009 In RDWAIT, the block SHALL:
- Drive mem_cmd=2'b10.
- Capture read_data into rd_data at the edge leaving RDWAIT.
- Move to ACK.
REQ-010 In ACK, reqN_ack SHALL be high for exactly one cycle for the granted requester only, and the FSM SHALL then return to IDLE.
REQ-011 Latency from arbitration edge to ack cycle SHALL be 2 cycles for writes and 3 cycles for reads, with one mandatory IDLE cycle between transactions.
REQ-012 mem_addr and write_data SHALL hold the latched values outside ISSUE; mem_cmd SHALL be 2'b10 in every state except ISSUE.
REQ-013 rd_data SHALL hold its value until the next read capture and SHALL not change on writes.
REQ-014 Requester handshake rules:
- A requester SHALL hold valid, write, addr and wdata stable until its ack.
- Changes to request inputs after the arbitration edge SHALL not affect the transaction in flight.
- valid still high in the IDLE cycle following an ack SHALL be treated as a new request.
REQ-015 The block SHALL sample request inputs only in IDLE, so a request asserted mid-transaction waits for IDLE.
REQ-016 Both ack outputs SHALL never be high in the same cycle.
REQ-017 With both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1,...

Reset
REQ-018 When reset_n is low at a rising clk edge, the block SHALL, regardless of state, including mid-transaction:
- Enter IDLE.
- Set mem_cmd=2'b10; mem_addr, write_data, rd_data = 0; req0_ack, req1_ack, busy = 0; grant_id=0; last_grant=1.
REQ-019 An aborted transaction SHALL produce no ack and no further bus command.
REQ-020 The first grant after reset SHALL go to requester 0 if both requesters are valid.

Verification
REQ-021 Single write: req0 write addr 9'h100, wdata 16'h00A5 -> one cycle of mem_cmd=01, addr 100, data 00A5; req0_ack 2 cycles after the arbitration edge.
REQ-022 Single read: req1 read addr 9'h010, read_data=16'h1234 in RDWAIT -> mem_cmd=00 for one cycle; req1_ack 3 cycles after arbitration; rd_data=1234.
REQ-023 Contention after reset: both valid continuously for 4 transactions -> ack order 0,1,0,1; req0_ack and req1_ack never overlap.
REQ-024 Request-change: req0 changes addr and wdata after the arbitration edge -> the bus shows the originally latched values.
REQ-025 Reset mid-read: reset_n low during RDWAIT -> next cycle IDLE; no ack; mem_cmd=10; rd_data=0; next contended grant goes to req0.
REQ-026 Idle bus: no valid for 10 cycles -> mem_cmd=10, busy=0, acks 0 throughout.
